// File: rtl/pc_sequencer.sv
// Program counter and fetch-redirect unit: prioritised next-PC selection, IF/ID flushes
// and an interrupt entry/return state machine with EPC capture.
module pc_sequencer #(
  parameter int unsigned ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h8000_0000,
  parameter logic [31:0] IRQ_VEC   = 32'h8000_0004,
  parameter logic [31:0] EXC_VEC   = 32'h8000_0008,
  parameter int unsigned KBIT      = ADDR_W - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_taken_ex,
  input  logic [ADDR_W-1:0] br_target_ex,
  input  logic              jmp_id,
  input  logic [ADDR_W-1:0] jmp_target_id,
  input  logic              jr_id,
  input  logic [ADDR_W-1:0] jr_target_id,
  input  logic              exc_id,
  input  logic              eret_id,
  input  logic [ADDR_W-1:0] pc_id,
  input  logic              irq,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              flush_if,
  output logic              flush_id,
  output logic              irq_ack,
  output logic [ADDR_W-1:0] epc,
  output logic              in_kernel
);

  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] IRQ_PC   = ADDR_W'(IRQ_VEC);
  localparam logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_VEC);
  localparam logic [ADDR_W-1:0] FOUR     = ADDR_W'(4);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT,
    ST_HANDLER
  } state_e;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_EXC,
    SRC_IRQ,
    SRC_BR,
    SRC_HOLD,
    SRC_ERET,
    SRC_JR,
    SRC_JMP
  } src_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              irq_ack_q, irq_ack_d;

  logic              irq_window;
  src_e              src;

  assign pc        = pc_q;
  assign pc_plus4  = pc_q + FOUR;
  assign epc       = epc_q;
  assign irq_ack   = irq_ack_q;
  assign in_kernel = pc_q[KBIT];

  // An interrupt is only taken on a cycle with no competing ID-stage redirect and no stall,
  // so the squashed ID instruction (or the resolved branch target) is a clean resume point.
  assign irq_window = (state_q != ST_HANDLER) && irq && !in_kernel && !stall &&
                      !jr_id && !jmp_id && !eret_id && !exc_id;

  always_comb begin
    src = SRC_SEQ;
    if (exc_id) begin
      src = SRC_EXC;
    end else if (irq_window) begin
      src = SRC_IRQ;
    end else if (br_taken_ex) begin
      src = SRC_BR;
    end else if (stall) begin
      src = SRC_HOLD;
    end else if (eret_id) begin
      src = SRC_ERET;
    end else if (jr_id) begin
      src = SRC_JR;
    end else if (jmp_id) begin
      src = SRC_JMP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      epc_q     <= '0;
      irq_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      irq_ack_q <= irq_ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_WAIT: begin
        if (src == SRC_EXC || src == SRC_IRQ) begin
          state_d = ST_HANDLER;
        end else if (irq) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      // An ERET squashed by a taken branch or a stall must not leave the handler.
      ST_HANDLER: begin
        if (src == SRC_ERET) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_d      = pc_plus4;
    epc_d     = epc_q;
    irq_ack_d = 1'b0;
    flush_if  = 1'b0;
    flush_id  = 1'b0;
    case (src)
      SRC_EXC: begin
        pc_d     = EXC_PC;
        flush_if = 1'b1;
        flush_id = 1'b1;
        if (state_q != ST_HANDLER) begin
          epc_d = pc_id + FOUR;
        end
      end
      SRC_IRQ: begin
        pc_d      = IRQ_PC;
        irq_ack_d = 1'b1;
        flush_if  = 1'b1;
        flush_id  = 1'b1;
        epc_d     = br_taken_ex ? br_target_ex : pc_id;
      end
      SRC_BR: begin
        pc_d     = br_target_ex;
        flush_if = 1'b1;
        flush_id = 1'b1;
      end
      SRC_HOLD: begin
        pc_d = pc_q;
      end
      SRC_ERET: begin
        pc_d     = epc_q;
        flush_if = 1'b1;
      end
      SRC_JR: begin
        pc_d     = jr_target_id;
        flush_if = 1'b1;
      end
      SRC_JMP: begin
        pc_d     = jmp_target_id;
        flush_if = 1'b1;
      end
      default: begin
        pc_d = pc_plus4;
      end
    endcase
    if (!reset) begin
      flush_if = 1'b0;
      flush_id = 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by randomized
// redirect traffic compared against a behavioural next-PC model.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_PC   = 32'h8000_0004;
  localparam logic [31:0] EXC_PC   = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, br_taken_ex, jmp_id, jr_id, exc_id, eret_id, irq;
  logic [31:0] br_target_ex, jmp_target_id, jr_target_id, pc_id;
  logic [31:0] pc, pc_plus4, epc;
  logic        flush_if, flush_id, irq_ack, in_kernel;

  int check_count = 0;
  int pass_count  = 0;

  // Reference model: architectural PC, EPC, ack pulse and "inside a handler" flag.
  logic [31:0] m_pc, m_epc;
  logic        m_ack, m_handler;
  logic        m_valid = 1'b0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .br_taken_ex   (br_taken_ex),
    .br_target_ex  (br_target_ex),
    .jmp_id        (jmp_id),
    .jmp_target_id (jmp_target_id),
    .jr_id         (jr_id),
    .jr_target_id  (jr_target_id),
    .exc_id        (exc_id),
    .eret_id       (eret_id),
    .pc_id         (pc_id),
    .irq           (irq),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .flush_if      (flush_if),
    .flush_id      (flush_id),
    .irq_ack       (irq_ack),
    .epc           (epc),
    .in_kernel     (in_kernel)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clearInputs();
    reset = 1'b1; stall = 1'b0; br_taken_ex = 1'b0; jmp_id = 1'b0; jr_id = 1'b0;
    exc_id = 1'b0; eret_id = 1'b0; irq = 1'b0;
    br_target_ex = '0; jmp_target_id = '0; jr_target_id = '0; pc_id = '0;
  endtask

  // Called just after a falling edge with inputs already driven; checks, clocks, advances model.
  task automatic applyStimulus();
    logic [31:0] n_pc, n_epc;
    logic        n_ack, n_handler, e_fi, e_fd, take;
    #1;
    n_pc = m_pc + 32'd4; n_epc = m_epc; n_ack = 1'b0; n_handler = m_handler;
    e_fi = 1'b0; e_fd = 1'b0;
    take = !m_handler && irq && !m_pc[31] && !stall && !jr_id && !jmp_id && !eret_id && !exc_id;
    if (!reset) begin
      n_pc = RESET_PC; n_epc = '0; n_handler = 1'b0;
    end else if (exc_id) begin
      n_pc = EXC_PC; e_fi = 1'b1; e_fd = 1'b1;
      if (!m_handler) begin
        n_epc = pc_id + 32'd4; n_handler = 1'b1;
      end
    end else if (take) begin
      n_pc = IRQ_PC; n_ack = 1'b1; n_handler = 1'b1; e_fi = 1'b1; e_fd = 1'b1;
      n_epc = br_taken_ex ? br_target_ex : pc_id;
    end else if (br_taken_ex) begin
      n_pc = br_target_ex; e_fi = 1'b1; e_fd = 1'b1;
    end else if (stall) begin
      n_pc = m_pc;
    end else if (eret_id) begin
      n_pc = m_epc; e_fi = 1'b1; n_handler = 1'b0;
    end else if (jr_id) begin
      n_pc = jr_target_id; e_fi = 1'b1;
    end else if (jmp_id) begin
      n_pc = jmp_target_id; e_fi = 1'b1;
    end
    if (m_valid) begin
      checkOutput("pc", pc, m_pc);
      checkOutput("pc_plus4", pc_plus4, m_pc + 32'd4);
      checkOutput("epc", epc, m_epc);
      checkOutput("irq_ack", {31'd0, irq_ack}, {31'd0, m_ack});
      checkOutput("in_kernel", {31'd0, in_kernel}, {31'd0, m_pc[31]});
    end
    if (m_valid || !reset) begin
      checkOutput("flush_if", {31'd0, flush_if}, {31'd0, e_fi});
      checkOutput("flush_id", {31'd0, flush_id}, {31'd0, e_fd});
    end
    @(posedge clk);
    if (m_valid || !reset) begin
      m_pc = n_pc; m_epc = n_epc; m_ack = n_ack; m_handler = n_handler;
      m_valid = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic jumpTo(input logic [31:0] target);
    clearInputs();
    jmp_id = 1'b1; jmp_target_id = target;
    applyStimulus();
  endtask

  function automatic logic [31:0] randTarget();
    if ($urandom_range(0, 7) == 0) return $urandom;
    return $urandom & 32'h0000_FFFC;
  endfunction

  initial begin
    clearInputs();
    reset = 1'b0;
    @(negedge clk);

    // Reset and sequential fetch from the reset vector
    applyStimulus();
    applyStimulus();
    clearInputs();
    checkOutput("tp1_pc_reset", pc, 32'h8000_0000);
    #1;
    checkOutput("tp1_flush_if", {31'd0, flush_if}, 32'd0);
    applyStimulus();
    checkOutput("tp1_pc_1", pc, 32'h8000_0004);
    applyStimulus();
    checkOutput("tp1_pc_2", pc, 32'h8000_0008);

    // Stalled jump holds, then proceeds with an IF-only flush
    jumpTo(32'h0000_0100);
    clearInputs();
    stall = 1'b1; jmp_id = 1'b1; jmp_target_id = 32'h0000_0200;
    #1;
    checkOutput("tp2_stall_flush_if", {31'd0, flush_if}, 32'd0);
    applyStimulus();
    checkOutput("tp2_pc_hold", pc, 32'h0000_0100);
    stall = 1'b0;
    #1;
    checkOutput("tp2_flush_if", {31'd0, flush_if}, 32'd1);
    checkOutput("tp2_flush_id", {31'd0, flush_id}, 32'd0);
    applyStimulus();
    checkOutput("tp2_pc_jmp", pc, 32'h0000_0200);

    // Taken branch overrides stall and jump
    clearInputs();
    br_taken_ex = 1'b1; br_target_ex = 32'h0000_0040; jmp_id = 1'b1;
    jmp_target_id = 32'h0000_0900; stall = 1'b1;
    #1;
    checkOutput("tp3_flush_id", {31'd0, flush_id}, 32'd1);
    applyStimulus();
    checkOutput("tp3_pc_br", pc, 32'h0000_0040);

    // Interrupt entry and ERET return
    jumpTo(32'h0000_0300);
    clearInputs();
    irq = 1'b1; pc_id = 32'h0000_02FC;
    applyStimulus();
    checkOutput("tp4_pc_irq", pc, IRQ_PC);
    checkOutput("tp4_ack", {31'd0, irq_ack}, 32'd1);
    checkOutput("tp4_epc", epc, 32'h0000_02FC);
    clearInputs();
    applyStimulus();
    checkOutput("tp4_ack_pulse", {31'd0, irq_ack}, 32'd0);
    jumpTo(32'h8000_0010);
    clearInputs();
    eret_id = 1'b1;
    applyStimulus();
    checkOutput("tp4_pc_eret", pc, 32'h0000_02FC);

    // Interrupt deferred behind JR, then taken on a clean cycle
    clearInputs();
    irq = 1'b1; jr_id = 1'b1; jr_target_id = 32'h0000_0500;
    applyStimulus();
    checkOutput("tp5_pc_jr", pc, 32'h0000_0500);
    checkOutput("tp5_no_ack", {31'd0, irq_ack}, 32'd0);
    clearInputs();
    irq = 1'b1; pc_id = 32'h0000_04FC;
    applyStimulus();
    checkOutput("tp5_pc_irq", pc, IRQ_PC);
    checkOutput("tp5_ack", {31'd0, irq_ack}, 32'd1);

    // Reset while in the handler, then irq in boot code is never taken
    clearInputs();
    reset = 1'b0; irq = 1'b1;
    applyStimulus();
    checkOutput("tp1h_pc", pc, RESET_PC);
    checkOutput("tp1h_epc", epc, 32'd0);
    for (int i = 0; i < 4; i++) begin
      clearInputs();
      irq = 1'b1;
      applyStimulus();
      checkOutput("tp5_kernel_no_ack", {31'd0, irq_ack}, 32'd0);
    end

    // Exception wins over a simultaneous interrupt; irq re-sampled after ERET
    jumpTo(32'h0000_0010);
    clearInputs();
    exc_id = 1'b1; irq = 1'b1; pc_id = 32'h0000_0010;
    applyStimulus();
    checkOutput("tp6_pc_exc", pc, EXC_PC);
    checkOutput("tp6_epc", epc, 32'h0000_0014);
    checkOutput("tp6_no_ack", {31'd0, irq_ack}, 32'd0);
    clearInputs();
    irq = 1'b1; eret_id = 1'b1;
    applyStimulus();
    checkOutput("tp6_pc_eret", pc, 32'h0000_0014);
    clearInputs();
    irq = 1'b1; pc_id = 32'h0000_0010;
    applyStimulus();
    checkOutput("tp6_ack_after_eret", {31'd0, irq_ack}, 32'd1);

    // Address wrap
    jumpTo(32'hFFFF_FFFC);
    checkOutput("wrap_plus4", pc_plus4, 32'd0);
    clearInputs();
    applyStimulus();
    checkOutput("wrap_pc", pc, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic keep_irq;
      keep_irq = irq;
      clearInputs();
      irq           = ($urandom_range(0, 3) == 0) ? ~keep_irq : keep_irq;
      reset         = ($urandom_range(0, 63) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      br_taken_ex   = ($urandom_range(0, 7) == 0);
      jmp_id        = ($urandom_range(0, 5) == 0);
      jr_id         = ($urandom_range(0, 7) == 0);
      exc_id        = ($urandom_range(0, 15) == 0);
      eret_id       = ($urandom_range(0, 7) == 0);
      br_target_ex  = randTarget();
      jmp_target_id = randTarget();
      jr_target_id  = randTarget();
      pc_id         = randTarget();
      applyStimulus();
    end

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
